// File: rtl/jstk_spi_responder_pkg.sv
// Shared definitions for the PmodJSTK SPI link (responder and master sides).
// Contents: frame/counter widths, command codes, FSM state type and the
// joystick frame packer used to build the transmit snapshot.
package jstk_spi_responder_pkg;

   localparam int unsigned JSTK_FRAME_BITS = 40;
   localparam int unsigned JSTK_CNT_W      = 6;
   localparam logic [5:0]  CMD_LED_PREFIX  = 6'b100000;
   localparam logic [7:0]  CMD_SET_RGB     = 8'h84;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_CHECK = 2'd2
   } jstk_state_t;

   // Joystick frame: X low, X high, Y low, Y high, buttons (first byte in MSBs)
   function automatic logic [JSTK_FRAME_BITS-1:0] jstk_pack_frame(
      input logic [9:0] xpos,
      input logic [9:0] ypos,
      input logic [2:0] btn
   );
      return {xpos[7:0], 6'b0, xpos[9:8], ypos[7:0], 6'b0, ypos[9:8], 5'b0, btn};
   endfunction

endpackage

// File: rtl/jstk_spi_responder_if.sv
// SPI pin bundle between a PmodJSTK master and the joystick responder.
// Signals: SS (active-low select), SCLK (mode 0), MOSI, MISO.
interface jstk_spi_responder_if;

   logic SS;
   logic SCLK;
   logic MOSI;
   logic MISO;

   modport master (output SS, output SCLK, output MOSI, input MISO);
   modport slave  (input SS, input SCLK, input MOSI, output MISO);

endinterface

// File: rtl/jstk_spi_responder_sync_edge.sv
// Two-FF synchronizer for an asynchronous pin plus a history FF for edge detect.
// Ports: clk, rst (sync, active-high), i_pin (async pin),
//        o_sync (synchronized level), o_rise_c / o_fall_c (one-cycle edge strobes).
module jstk_spi_responder_sync_edge #(
   parameter logic RESET_VAL = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic i_pin,
   output logic o_sync,
   output logic o_rise_c,
   output logic o_fall_c
);

   logic r_meta;
   logic r_sync;
   logic r_hist;

   // Synchronizer chain; history holds the previous synchronized level
   always_ff @(posedge clk) begin
      if (rst) begin
         r_meta <= RESET_VAL;
         r_sync <= RESET_VAL;
         r_hist <= RESET_VAL;
      end else begin
         r_meta <= i_pin;
         r_sync <= r_meta;
         r_hist <= r_sync;
      end
   end

   assign o_sync   = r_sync;
   assign o_rise_c = r_sync & ~r_hist;
   assign o_fall_c = ~r_sync & r_hist;

endmodule

// File: rtl/jstk_spi_responder.sv
// SPI mode-0 slave acting as the joystick end of a PmodJSTK link.
// Sends a 5-byte position/button snapshot and captures a 5-byte command frame.
// Ports: clk, rst (sync, active-high); spi (SS/SCLK/MOSI in, MISO out);
//        xpos/ypos/btn snapshot inputs; rx_cmd/rx_payload last good frame;
//        rx_valid/rx_err frame-end pulses; led/rgb decoded command registers.
module jstk_spi_responder
   import jstk_spi_responder_pkg::*;
#(
   parameter int unsigned SCLK_MIN_HALF = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   jstk_spi_responder_if.slave   spi,
   input  logic [9:0]            xpos,
   input  logic [9:0]            ypos,
   input  logic [2:0]            btn,
   output logic [7:0]            rx_cmd,
   output logic [31:0]           rx_payload,
   output logic                  rx_valid,
   output logic                  rx_err,
   output logic [1:0]            led,
   output logic [23:0]           rgb
);

   localparam logic [JSTK_CNT_W-1:0] CNT_FRAME = JSTK_CNT_W'(JSTK_FRAME_BITS);
   localparam logic [JSTK_CNT_W-1:0] CNT_MAX   = '1;

   // MISO is only re-timed 3 clk after an edge, so slower SCLK is assumed
   if (SCLK_MIN_HALF < 4) begin : g_half_check
      $error("SCLK_MIN_HALF below 4 leaves no MISO setup margin");
   end

   logic w_ss_sync, w_ss_rise, w_ss_fall;
   logic w_sclk_rise, w_sclk_fall, w_mosi_sync;
   logic w_sclk_sync_unused, w_mosi_rise_unused, w_mosi_fall_unused;

   jstk_spi_responder_sync_edge #(.RESET_VAL(1'b1)) u_sync_ss (
      .clk(clk), .rst(rst), .i_pin(spi.SS),
      .o_sync(w_ss_sync), .o_rise_c(w_ss_rise), .o_fall_c(w_ss_fall));

   jstk_spi_responder_sync_edge #(.RESET_VAL(1'b0)) u_sync_sclk (
      .clk(clk), .rst(rst), .i_pin(spi.SCLK),
      .o_sync(w_sclk_sync_unused), .o_rise_c(w_sclk_rise), .o_fall_c(w_sclk_fall));

   jstk_spi_responder_sync_edge #(.RESET_VAL(1'b0)) u_sync_mosi (
      .clk(clk), .rst(rst), .i_pin(spi.MOSI),
      .o_sync(w_mosi_sync), .o_rise_c(w_mosi_rise_unused), .o_fall_c(w_mosi_fall_unused));

   jstk_state_t                  r_state, w_state_nxt;
   logic [JSTK_FRAME_BITS-1:0]   r_tx_sr, r_rx_sr, w_snap;
   logic [JSTK_CNT_W-1:0]        r_bit_cnt;
   logic [1:0]                   r_settle;
   logic                         r_armed, r_miso, r_rx_valid, r_rx_err;
   logic [7:0]                   r_rx_cmd;
   logic [31:0]                  r_rx_payload;
   logic [1:0]                   r_led;
   logic [23:0]                  r_rgb;
   logic w_start, w_bit_in, w_bit_out, w_miso_clr, w_frame_ok, w_frame_err;

   assign w_snap = jstk_pack_frame(xpos, ypos, btn);

   // State register
   always_ff @(posedge clk) begin
      if (rst) r_state <= ST_IDLE;
      else     r_state <= w_state_nxt;
   end

   // Next state and datapath strobes
   always_comb begin
      w_state_nxt = r_state;
      w_start     = 1'b0;
      w_bit_in    = 1'b0;
      w_bit_out   = 1'b0;
      w_miso_clr  = 1'b0;
      w_frame_ok  = 1'b0;
      w_frame_err = 1'b0;
      unique case (r_state)
         ST_IDLE: begin
            if (w_ss_fall && r_armed) begin
               w_start     = 1'b1;
               w_state_nxt = ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            w_bit_in  = w_sclk_rise;
            w_bit_out = w_sclk_fall;
            if (w_ss_rise) w_state_nxt = ST_CHECK;
         end
         ST_CHECK: begin
            w_state_nxt = ST_IDLE;
            w_miso_clr  = 1'b1;
            if (r_bit_cnt == CNT_FRAME)  w_frame_ok  = 1'b1;
            else if (r_bit_cnt != '0)    w_frame_err = 1'b1;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // Shift registers, bit counter, command decode
   always_ff @(posedge clk) begin
      if (rst) begin
         r_tx_sr      <= '0;
         r_rx_sr      <= '0;
         r_bit_cnt    <= '0;
         r_settle     <= '0;
         r_armed      <= 1'b0;
         r_miso       <= 1'b0;
         r_rx_valid   <= 1'b0;
         r_rx_err     <= 1'b0;
         r_rx_cmd     <= '0;
         r_rx_payload <= '0;
         r_led        <= '0;
         r_rgb        <= '0;
      end else begin
         r_rx_valid <= w_frame_ok;
         r_rx_err   <= w_frame_err;
         // Only arm once SS has been seen high after reset; a select that
         // was already low at reset release must not start a frame.
         r_settle   <= {r_settle[0], 1'b1};
         if (r_settle[1] && w_ss_sync) r_armed <= 1'b1;

         if (w_start) begin
            r_tx_sr   <= w_snap;
            r_miso    <= w_snap[JSTK_FRAME_BITS-1];
            r_bit_cnt <= '0;
         end
         if (w_bit_in) begin
            r_rx_sr <= {r_rx_sr[JSTK_FRAME_BITS-2:0], w_mosi_sync};
            if (r_bit_cnt != CNT_MAX) r_bit_cnt <= r_bit_cnt + JSTK_CNT_W'(1);
         end
         if (w_bit_out) begin
            r_tx_sr <= {r_tx_sr[JSTK_FRAME_BITS-2:0], 1'b0};
            r_miso  <= r_tx_sr[JSTK_FRAME_BITS-2];
         end
         if (w_miso_clr) r_miso <= 1'b0;

         if (w_frame_ok) begin
            r_rx_cmd     <= r_rx_sr[39:32];
            r_rx_payload <= r_rx_sr[31:0];
            if (r_rx_sr[39:34] == CMD_LED_PREFIX) r_led <= r_rx_sr[33:32];
            if (r_rx_sr[39:32] == CMD_SET_RGB)    r_rgb <= r_rx_sr[31:8];
         end
      end
   end

   assign spi.MISO   = r_miso;
   assign rx_cmd     = r_rx_cmd;
   assign rx_payload = r_rx_payload;
   assign rx_valid   = r_rx_valid;
   assign rx_err     = r_rx_err;
   assign led        = r_led;
   assign rgb        = r_rgb;

endmodule

// File: tb/tb_jstk_spi_responder.sv
// Self-checking bench for jstk_spi_responder: a behavioural SPI master plus a
// frame-level reference model checked against the DUT outputs every cycle.
module tb_jstk_spi_responder;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [9:0]  xpos, ypos;
   logic [2:0]  btn;
   logic [7:0]  rx_cmd;
   logic [31:0] rx_payload;
   logic        rx_valid, rx_err;
   logic [1:0]  led;
   logic [23:0] rgb;

   jstk_spi_responder_if spi();

   jstk_spi_responder #(.SCLK_MIN_HALF(4)) dut (
      .clk(clk), .rst(rst), .spi(spi),
      .xpos(xpos), .ypos(ypos), .btn(btn),
      .rx_cmd(rx_cmd), .rx_payload(rx_payload),
      .rx_valid(rx_valid), .rx_err(rx_err),
      .led(led), .rgb(rgb));

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;
   int n_valid = 0;
   int unsigned cyc = 0;
   bit rst_q = 1'b1;
   bit chk_en = 1'b0;
   int ss_hi_cnt = 0;

   // Frame-end event expected at a given cycle count
   typedef struct {
      int unsigned at;
      bit          ok;
      bit          err;
      logic [39:0] frame;
   } evt_t;
   evt_t evq[$];

   logic [7:0]  m_cmd;
   logic [31:0] m_payload;
   logic [1:0]  m_led;
   logic [23:0] m_rgb;
   logic        e_valid, e_err;
   evt_t        ev;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Bytes on the wire: X low, X high, Y low, Y high, buttons
   function automatic logic [39:0] model_tx(input int unsigned x, input int unsigned y, input int unsigned b);
      logic [7:0] b0, b1, b2, b3, b4;
      b0 = 8'(x % 256);
      b1 = 8'(x / 256);
      b2 = 8'(y % 256);
      b3 = 8'(y / 256);
      b4 = 8'(b);
      return {b0, b1, b2, b3, b4};
   endfunction

   always @(posedge clk) begin
      cyc   <= cyc + 1;
      rst_q <= rst;
   end

   // Compare process: apply due frame events to the model, then check outputs
   initial begin : compare
      forever begin
         @(negedge clk);
         e_valid = 1'b0;
         e_err   = 1'b0;
         if (rst_q) begin
            m_cmd = '0; m_payload = '0; m_led = '0; m_rgb = '0;
            evq.delete();
         end else if (evq.size() > 0 && evq[0].at == cyc) begin
            ev = evq.pop_front();
            e_valid = ev.ok;
            e_err   = ev.err;
            if (ev.ok) begin
               m_cmd     = ev.frame[39:32];
               m_payload = ev.frame[31:0];
               if (ev.frame[39:34] == 6'b100000) m_led = ev.frame[33:32];
               if (ev.frame[39:32] == 8'h84)     m_rgb = ev.frame[31:8];
            end
         end
         if (chk_en) begin
            check("rx_valid", rx_valid, e_valid);
            check("rx_err", rx_err, e_err);
            check("rx_cmd", rx_cmd, m_cmd);
            check("rx_payload", rx_payload, m_payload);
            check("led", led, m_led);
            check("rgb", rgb, m_rgb);
            if (ss_hi_cnt >= 5 || rst_q) check("miso_idle", spi.MISO, 1'b0);
         end
         if (rx_valid === 1'b1) n_valid++;
         ss_hi_cnt = (spi.SS === 1'b1) ? ss_hi_cnt + 1 : 0;
      end
   end

   // Master: clock nbits of frame (zeros past bit 40), checking each MISO bit
   task automatic run_frame(input logic [39:0] frame, input int nbits, input int h,
                            input int ss_hi, input bit gaps, input bit chg_x,
                            input int rst_at, output logic [63:0] got);
      logic [39:0] exp_tx;
      evt_t        e;
      logic        exp_bit;
      got = '0;
      repeat (ss_hi) @(negedge clk);
      exp_tx   = model_tx(xpos, ypos, btn);
      spi.SS   = 1'b0;
      spi.MOSI = (nbits > 0) ? frame[39] : 1'b0;
      for (int i = 0; i < nbits; i++) begin
         if (i == rst_at) begin
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
            repeat (6) @(negedge clk);
            check("miso_after_rst", spi.MISO, 1'b0);
            repeat (h) @(negedge clk);
            spi.SS   = 1'b1;
            spi.MOSI = 1'b0;
            return;
         end
         repeat (h) @(negedge clk);
         if (chg_x && i == 20) begin
            xpos = 10'($urandom);
            ypos = 10'($urandom);
            btn  = 3'($urandom);
         end
         exp_bit = (i < 40) ? exp_tx[39 - i] : 1'b0;
         got = {got[62:0], spi.MISO};
         check("miso_bit", spi.MISO, exp_bit);
         spi.SCLK = 1'b1;
         repeat (h) @(negedge clk);
         spi.SCLK = 1'b0;
         spi.MOSI = (i + 1 < 40) ? frame[38 - i] : 1'b0;
         if (gaps && (i % 8) == 7) repeat ($urandom_range(0, 20)) @(negedge clk);
      end
      repeat (h) @(negedge clk);
      spi.SS   = 1'b1;
      spi.MOSI = 1'b0;
      e.at    = cyc + 4;
      e.ok    = (nbits == 40);
      e.err   = (nbits != 0 && nbits != 40);
      e.frame = frame;
      if (e.ok || e.err) evq.push_back(e);
   endtask

   initial begin : driver
      logic [63:0] got;
      int v0;
      spi.SS = 1'b1; spi.SCLK = 1'b0; spi.MOSI = 1'b0;
      xpos = '0; ypos = '0; btn = '0;
      rst = 1'b1;
      repeat (5) @(negedge clk);
      rst = 1'b0;
      chk_en = 1'b1;
      check("reset_rx_cmd", rx_cmd, 8'h00);
      check("reset_miso", spi.MISO, 1'b0);
      repeat (5) @(negedge clk);

      // Snapshot bytes and LED command
      xpos = 10'h2A5; ypos = 10'h13C; btn = 3'b101;
      run_frame(40'h8300000000, 40, 8, 4, 1'b0, 1'b0, -1, got);
      check("tx_bytes_A5023C0105", got[39:0], 40'hA5023C0105);
      repeat (6) @(negedge clk);
      check("lit_cmd_83", rx_cmd, 8'h83);
      check("lit_led_11", led, 2'b11);
      check("lit_rgb_0", rgb, 24'h0);

      // RGB command
      run_frame(40'h84FF801000, 40, 8, 4, 1'b0, 1'b0, -1, got);
      repeat (6) @(negedge clk);
      check("lit_rgb_FF8010", rgb, 24'hFF8010);
      check("lit_payload", rx_payload, 32'hFF801000);
      check("lit_led_kept", led, 2'b11);

      // Short and long frames
      v0 = n_valid;
      run_frame(40'h1234567890, 17, 5, 4, 1'b0, 1'b0, -1, got);
      repeat (6) @(negedge clk);
      check("short_no_valid", 64'(n_valid - v0), 64'd0);
      check("short_cmd_kept", rx_cmd, 8'h84);
      run_frame(40'h8100000000, 41, 5, 4, 1'b0, 1'b0, -1, got);
      check("miso_bit41_zero", got[0], 1'b0);
      repeat (6) @(negedge clk);
      check("long_led_kept", led, 2'b11);

      // Snapshot held while inputs change mid-frame
      xpos = 10'h155; ypos = 10'h0AA; btn = 3'b010;
      run_frame(40'h8200000000, 40, 6, 4, 1'b1, 1'b1, -1, got);
      check("snap_mid_change", got[39:0], 40'h5501AA0002);
      repeat (6) @(negedge clk);
      check("lit_led_10", led, 2'b10);

      // Back-to-back frames, minimum SS high time
      v0 = n_valid;
      run_frame(40'h8100000000, 40, 5, 4, 1'b0, 1'b0, -1, got);
      run_frame(40'h80ABCDEF01, 40, 5, 2, 1'b0, 1'b0, -1, got);
      repeat (8) @(negedge clk);
      check("b2b_two_pulses", 64'(n_valid - v0), 64'd2);
      check("b2b_led_00", led, 2'b00);

      // Reset mid-frame with SS held low, then a clean frame
      run_frame(40'h8300000000, 40, 6, 4, 1'b0, 1'b0, 20, got);
      repeat (8) @(negedge clk);
      check("rst_cmd_cleared", rx_cmd, 8'h00);
      check("rst_miso_low", spi.MISO, 1'b0);
      run_frame(40'h8301020304, 40, 6, 10, 1'b0, 1'b0, -1, got);
      repeat (6) @(negedge clk);
      check("post_rst_cmd", rx_cmd, 8'h83);
      check("post_rst_payload", rx_payload, 32'h01020304);

      // Randomized frames
      for (int k = 0; k < 20; k++) begin
         logic [39:0] fr;
         int nb, sel;
         xpos = 10'($urandom); ypos = 10'($urandom); btn = 3'($urandom);
         fr[31:0] = $urandom;
         sel = $urandom_range(0, 3);
         case (sel)
            0:       fr[39:32] = {6'b100000, 2'($urandom)};
            1:       fr[39:32] = 8'h84;
            2:       fr[39:32] = 8'($urandom);
            default: fr[39:32] = 8'h83;
         endcase
         sel = $urandom_range(0, 9);
         nb = (sel == 0) ? 0 : (sel == 1) ? $urandom_range(1, 39) : (sel == 2) ? 41 : 40;
         run_frame(fr, nb, $urandom_range(4, 9), $urandom_range(2, 10),
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), -1, got);
      end
      repeat (20) @(negedge clk);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
